// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among N write-back
// requesters; registered WA/WD/WERF drive the register file directly.
module regfile_wb_arbiter #(
    parameter int N                = 4,
    parameter int ADDR_W           = 5,
    parameter int DATA_W           = 32,
    parameter int ZERO_REG_PROTECT = 1,
    parameter int CNT_W            = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req_valid,
    input  logic [N*ADDR_W-1:0]    req_addr,
    input  logic [N*DATA_W-1:0]    req_data,
    output logic [N-1:0]           req_ready,
    input  logic                   wb_stall,
    output logic [ADDR_W-1:0]      WA,
    output logic [DATA_W-1:0]      WD,
    output logic                   WERF,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic [CNT_W-1:0]       conflict_cnt
);

    localparam int IDW = $clog2(N);

    logic [IDW-1:0]    r_rr_ptr;
    logic [ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wd;
    logic              r_werf;
    logic [IDW-1:0]    r_grant_id;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_found;
    logic [IDW-1:0]    w_gidx;
    logic [IDW:0]      w_sum;
    logic [N-1:0]      w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [IDW-1:0]    w_next_ptr;
    logic              w_multi;
    logic              w_block_zero;

    // Handshake: requester i transfers on the edge where req_valid[i] & req_ready[i];
    // req_ready is a combinational one-hot that never depends on itself, is 0 in
    // reset or stall, and the requester must hold valid/addr/data until accepted.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N)) begin
                w_sum = w_sum - (IDW+1)'(N);
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[IDW-1:0];
            end
        end
        if (wb_stall || !rst_n) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_found) begin
            w_ready[w_gidx] = 1'b1;
        end
    end

    assign req_ready    = w_ready;
    assign w_addr       = req_addr[w_gidx*ADDR_W +: ADDR_W];
    assign w_data       = req_data[w_gidx*DATA_W +: DATA_W];
    assign w_next_ptr   = (w_gidx == IDW'(N-1)) ? '0 : w_gidx + IDW'(1);
    assign w_multi      = ($countones(req_valid) > 1);
    // Writes to r0 still complete the handshake so the requester is released.
    assign w_block_zero = (ZERO_REG_PROTECT != 0) && (w_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_wa       <= '0;
            r_wd       <= '0;
            r_werf     <= 1'b0;
            r_grant_id <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_found) begin
                r_wa       <= w_addr;
                r_wd       <= w_data;
                r_grant_id <= w_gidx;
                r_werf     <= !w_block_zero;
                r_rr_ptr   <= w_next_ptr;
            end else begin
                r_werf     <= 1'b0;
            end
            if (w_multi && !wb_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign WA           = r_wa;
    assign WD           = r_wd;
    assign WERF         = r_werf;
    assign grant_id     = r_grant_id;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus hand-written reset,
// fairness and saturation sequences; a CNT_W=2 twin shares the inputs.
module tb_regfile_wb_arbiter;

    localparam int N      = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N*ADDR_W-1:0]  req_addr;
    logic [N*DATA_W-1:0]  req_data;
    logic [N-1:0]         req_ready;
    logic                 wb_stall;
    logic [ADDR_W-1:0]    WA;
    logic [DATA_W-1:0]    WD;
    logic                 WERF;
    logic [1:0]           grant_id;
    logic [15:0]          conflict_cnt;

    logic [N-1:0]         s_req_ready;
    logic [ADDR_W-1:0]    s_wa;
    logic [DATA_W-1:0]    s_wd;
    logic                 s_werf;
    logic [1:0]           s_grant_id;
    logic [1:0]           s_cnt;

    regfile_wb_arbiter #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .ZERO_REG_PROTECT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
        .WA(WA), .WD(WD), .WERF(WERF), .grant_id(grant_id),
        .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .ZERO_REG_PROTECT(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(s_req_ready), .wb_stall(wb_stall),
        .WA(s_wa), .WD(s_wd), .WERF(s_werf), .grant_id(s_grant_id),
        .conflict_cnt(s_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [N*ADDR_W-1:0] A_DEF = {5'd13, 5'd12, 5'd11, 5'd10};
    localparam logic [N*DATA_W-1:0] D_DEF = {32'hD3D3_0003, 32'hD2D2_0002,
                                             32'hD1D1_0001, 32'hD0D0_0000};

    typedef struct {
        logic [N-1:0]        valid;
        logic                stall;
        logic [N*ADDR_W-1:0] addr;
        logic [N*DATA_W-1:0] data;
        logic [N-1:0]        exp_ready;
        logic                exp_werf;
        logic [ADDR_W-1:0]   exp_wa;
        logic [DATA_W-1:0]   exp_wd;
        logic [1:0]          exp_gid;
        logic [15:0]         exp_cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    logic [1:0] exp_q[$];
    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [N-1:0] v, input logic st,
                           input logic [N*ADDR_W-1:0] a, input logic [N*DATA_W-1:0] d,
                           input logic [N-1:0] rdy, input logic we,
                           input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                           input logic [1:0] gid, input logic [15:0] cnt);
        vecs[i].valid     = v;
        vecs[i].stall     = st;
        vecs[i].addr      = a;
        vecs[i].data      = d;
        vecs[i].exp_ready = rdy;
        vecs[i].exp_werf  = we;
        vecs[i].exp_wa    = wa;
        vecs[i].exp_wd    = wd;
        vecs[i].exp_gid   = gid;
        vecs[i].exp_cnt   = cnt;
    endtask

    // driver: inputs change 1 time unit after the rising edge
    task automatic drive(input logic [N-1:0] v, input logic st,
                         input logic [N*ADDR_W-1:0] a, input logic [N*DATA_W-1:0] d);
        req_valid = v;
        wb_stall  = st;
        req_addr  = a;
        req_data  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] sat;
        n_tests = 0;
        n_fail  = 0;

        // From reset: rr_ptr=0, cnt=0, WA/WD/grant_id=0
        set_vec(0,  4'b0100, 1'b0, {5'd13, 5'd7, 5'd11, 5'd10},
                {32'hD3D3_0003, 32'hDEAD_BEEF, 32'hD1D1_0001, 32'hD0D0_0000},
                4'b0100, 1'b1, 5'd7,  32'hDEAD_BEEF, 2'd2, 16'd0);
        set_vec(1,  4'b0000, 1'b0, A_DEF, D_DEF,
                4'b0000, 1'b0, 5'd7,  32'hDEAD_BEEF, 2'd2, 16'd0);
        set_vec(2,  4'b1111, 1'b0, A_DEF, D_DEF,
                4'b1000, 1'b1, 5'd13, 32'hD3D3_0003, 2'd3, 16'd1);
        set_vec(3,  4'b0001, 1'b0, A_DEF, D_DEF,
                4'b0001, 1'b1, 5'd10, 32'hD0D0_0000, 2'd0, 16'd1);
        set_vec(4,  4'b1001, 1'b0, A_DEF, D_DEF,
                4'b1000, 1'b1, 5'd13, 32'hD3D3_0003, 2'd3, 16'd2);
        set_vec(5,  4'b1001, 1'b0, A_DEF, D_DEF,
                4'b0001, 1'b1, 5'd10, 32'hD0D0_0000, 2'd0, 16'd3);
        set_vec(6,  4'b0010, 1'b0, {5'd13, 5'd12, 5'd0, 5'd10},
                {32'hD3D3_0003, 32'hD2D2_0002, 32'h0000_0005, 32'hD0D0_0000},
                4'b0010, 1'b0, 5'd0,  32'h0000_0005, 2'd1, 16'd3);
        set_vec(7,  4'b1111, 1'b0, A_DEF, D_DEF,
                4'b0100, 1'b1, 5'd12, 32'hD2D2_0002, 2'd2, 16'd4);
        set_vec(8,  4'b1111, 1'b1, A_DEF, D_DEF,
                4'b0000, 1'b0, 5'd12, 32'hD2D2_0002, 2'd2, 16'd4);
        set_vec(9,  4'b1111, 1'b1, A_DEF, D_DEF,
                4'b0000, 1'b0, 5'd12, 32'hD2D2_0002, 2'd2, 16'd4);
        set_vec(10, 4'b1111, 1'b1, A_DEF, D_DEF,
                4'b0000, 1'b0, 5'd12, 32'hD2D2_0002, 2'd2, 16'd4);
        set_vec(11, 4'b1111, 1'b0, A_DEF, D_DEF,
                4'b1000, 1'b1, 5'd13, 32'hD3D3_0003, 2'd3, 16'd5);
        set_vec(12, 4'b0110, 1'b0, A_DEF, D_DEF,
                4'b0010, 1'b1, 5'd11, 32'hD1D1_0001, 2'd1, 16'd6);
        set_vec(13, 4'b0110, 1'b0, A_DEF, D_DEF,
                4'b0100, 1'b1, 5'd12, 32'hD2D2_0002, 2'd2, 16'd7);
        set_vec(14, 4'b0001, 1'b0, A_DEF, D_DEF,
                4'b0001, 1'b1, 5'd10, 32'hD0D0_0000, 2'd0, 16'd7);
        set_vec(15, 4'b0001, 1'b1, A_DEF, D_DEF,
                4'b0000, 1'b0, 5'd10, 32'hD0D0_0000, 2'd0, 16'd7);

        // Reset state, with requests present to show req_ready is gated
        rst_n = 1'b0;
        drive(4'b1111, 1'b0, A_DEF, D_DEF);
        repeat (2) step();
        chk("rst_ready", 64'(req_ready), 64'(4'b0000));
        chk("rst_werf",  64'(WERF), 64'(1'b0));
        chk("rst_wa",    64'(WA), 64'(5'd0));
        chk("rst_wd",    64'(WD), 64'(32'd0));
        chk("rst_gid",   64'(grant_id), 64'(2'd0));
        chk("rst_cnt",   64'(conflict_cnt), 64'(16'd0));
        drive(4'b0000, 1'b0, A_DEF, D_DEF);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].stall, vecs[i].addr, vecs[i].data);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            if (i == 15) begin
                // transfer registered on the edge before stall still writes now
                chk("v15_werf_in_stall", 64'(WERF), 64'(1'b1));
            end
            step();
            sat = (vecs[i].exp_cnt > 16'd3) ? 16'd3 : vecs[i].exp_cnt;
            chk($sformatf("v%0d_werf", i), 64'(WERF), 64'(vecs[i].exp_werf));
            chk($sformatf("v%0d_wa", i),   64'(WA), 64'(vecs[i].exp_wa));
            chk($sformatf("v%0d_wd", i),   64'(WD), 64'(vecs[i].exp_wd));
            chk($sformatf("v%0d_gid", i),  64'(grant_id), 64'(vecs[i].exp_gid));
            chk($sformatf("v%0d_cnt", i),  64'(conflict_cnt), 64'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_satcnt", i), 64'(s_cnt), 64'(sat));
        end

        // Mid-transfer async reset: a write is pending in the output register
        drive(4'b1111, 1'b0, A_DEF, D_DEF);
        step();
        chk("pre_rst_werf", 64'(WERF), 64'(1'b1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_werf",   64'(WERF), 64'(1'b0));
        chk("async_rst_cnt",    64'(conflict_cnt), 64'(16'd0));
        chk("async_rst_satcnt", 64'(s_cnt), 64'(2'd0));
        chk("async_rst_ready",  64'(req_ready), 64'(4'b0000));
        chk("async_rst_wa",     64'(WA), 64'(5'd0));
        chk("async_rst_gid",    64'(grant_id), 64'(2'd0));

        // All four valid continuously out of reset: strict rotation
        for (int g = 0; g < 8; g++) exp_q.push_back(2'(g % N));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            logic [1:0] e;
            step();
            e = exp_q.pop_front();
            chk($sformatf("rr%0d_gid", c),  64'(grant_id), 64'(e));
            chk($sformatf("rr%0d_werf", c), 64'(WERF), 64'(1'b1));
            chk($sformatf("rr%0d_wa", c),   64'(WA), 64'(5'd10 + 5'(e)));
        end
        chk("rr_cnt",    64'(conflict_cnt), 64'(16'd8));
        chk("rr_satcnt", 64'(s_cnt), 64'(2'd3));
        chk("rr_queue_empty", 64'(exp_q.size()), 64'(0));

        drive(4'b0000, 1'b0, A_DEF, D_DEF);
        step();
        chk("idle_werf", 64'(WERF), 64'(1'b0));
        chk("idle_cnt",  64'(conflict_cnt), 64'(16'd8));
        chk("idle_gid",  64'(grant_id), 64'(2'd3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
